// File: rtl/button_event_ctrl.sv
// Purpose : turns a debounced button level into clk_50M event pulses (press, release, short, long, repeat) and a press count.
// Latency : press/release/short pulses appear 4 cycles after btn_deb is first sampled; long/repeat are counted from press_pulse.
// Backpr. : none; the button cannot be stalled, so every event is a one-cycle pulse with no handshake.
//
// Ports:
//   clk_50M     in   50 MHz system clock
//   clr_L       in   asynchronous active-low reset
//   btn_deb     in   debounced button level, asynchronous to clk_50M
//   held        out  registered "pressed" level (state != IDLE)
//   press_pulse out  one-cycle pulse on press
//   rel_pulse   out  one-cycle pulse on every release
//   short_pulse out  one-cycle pulse on release before the long threshold
//   long_pulse  out  one-cycle pulse when the hold reaches LONG_CNT
//   rpt_pulse   out  one-cycle pulse every REPEAT_CNT cycles while long-held
//   press_count out  presses since reset, modulo 256
module button_event_ctrl #(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned LONG_CNT   = 50_000_000,
    parameter int unsigned REPEAT_CNT = 12_500_000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic       clk_50M,
    input  logic       clr_L,
    input  logic       btn_deb,
    output logic       held,
    output logic       press_pulse,
    output logic       rel_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       rpt_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);

    logic             s1_q, s1_d, s2_q, s2_d;
    logic             p;
    logic             p_q, p_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             press_q, press_d, rel_q, rel_d, short_q, short_d;
    logic             long_q, long_d, rpt_q, rpt_d;
    logic [7:0]       count_q, count_d;

    // Normalized level: 1 means pressed regardless of board polarity.
    assign p = s2_q ^ ACTIVE_LOW;

    always_comb begin
        s1_d    = btn_deb;
        s2_d    = s1_q;
        p_d     = p;
        // Edges are registered so the FSM sees a clean one-cycle strobe.
        rise_d  = p & ~p_q;
        fall_d  = ~p & p_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise_q) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            PRESSED: begin
                // Release is checked first so it beats a coincident long threshold.
                if (fall_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                    short_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                // Release also suppresses a coincident repeat.
                if (fall_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (cnt_q == RPT_LAST) begin
                    cnt_d = '0;
                    rpt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50M or negedge clr_L) begin
        if (!clr_L) begin
            // Sync chain resets to the released level, so a button held
            // through reset produces exactly one press afterwards.
            s1_q    <= ACTIVE_LOW;
            s2_q    <= ACTIVE_LOW;
            p_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            p_q     <= p_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            short_q <= short_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            count_q <= count_d;
        end
    end

    assign held        = held_q;
    assign press_pulse = press_q;
    assign rel_pulse   = rel_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign rpt_pulse   = rpt_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Purpose : randomized scoreboard bench for button_event_ctrl with a press-length based event model.
// Latency : expected events are timestamped in clk_50M cycles from the first sampling edge of each press.
// Backpr. : none; the monitor pops one expected event whenever the DUT shows a pulse or an event is due.
module tb_button_event_ctrl;

    localparam int LONG = 20;
    localparam int RPT  = 5;
    localparam int HMAX = 16384;

    typedef struct {
        int         cyc;
        logic [4:0] vec;   // {press, rel, short, long, rpt}
        logic [7:0] cnt;
    } ev_t;

    logic       clk_50M = 1'b0;
    logic       clr_L;
    logic       btn_deb;
    logic       held;
    logic       press_pulse, rel_pulse, short_pulse, long_pulse, rpt_pulse;
    logic [7:0] press_count;

    button_event_ctrl #(
        .ACTIVE_LOW (1'b1),
        .LONG_CNT   (LONG),
        .REPEAT_CNT (RPT),
        .CNT_W      (8)
    ) dut (
        .clk_50M     (clk_50M),
        .clr_L       (clr_L),
        .btn_deb     (btn_deb),
        .held        (held),
        .press_pulse (press_pulse),
        .rel_pulse   (rel_pulse),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .rpt_pulse   (rpt_pulse),
        .press_count (press_count)
    );

    always #10 clk_50M = ~clk_50M;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    bit         exp_held [HMAX];
    ev_t        evq [$];
    logic [7:0] mcount = 8'd0;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [4:0] v, input logic [7:0] n);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        e.cnt = n;
        evq.push_back(e);
    endtask

    task automatic set_held(input int from, input int to);
        for (int i = from; i <= to; i++)
            if (i >= 0 && i < HMAX) exp_held[i] = 1'b1;
    endtask

    // A press of n sampled cycles whose first pressed sample is at edge s:
    // press at s+3, long at s+3+LONG if n > LONG, repeats every RPT after
    // that while still before the release, release at s+3+n.
    task automatic do_press(input int n, input int gap);
        int s;
        s = cyc + 1;
        btn_deb = 1'b0;
        mcount = mcount + 8'd1;
        push_ev(s + 3, 5'b10000, mcount);
        if (n > LONG) begin
            push_ev(s + 3 + LONG, 5'b00010, mcount);
            for (int j = 1; LONG + j * RPT < n; j++)
                push_ev(s + 3 + LONG + j * RPT, 5'b00001, mcount);
            push_ev(s + 3 + n, 5'b01000, mcount);
        end else begin
            push_ev(s + 3 + n, 5'b01100, mcount);
        end
        set_held(s + 3, s + 2 + n);
        tick(n);
        btn_deb = 1'b1;
        tick(gap);
    endtask

    always @(negedge clk_50M) begin
        if (mon_en) begin
            logic [4:0] obs;
            ev_t        e;
            obs = {press_pulse, rel_pulse, short_pulse, long_pulse, rpt_pulse};
            check("held", int'(held), (cyc < HMAX) ? int'(exp_held[cyc]) : 0);
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_event: vec %b due at cycle %0d never seen", e.vec, e.cyc);
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                check("pulse_vec", int'(obs), int'(e.vec));
                check("press_count", int'(press_count), int'(e.cnt));
            end else if (obs != 5'b0) begin
                check("unexpected_pulse", int'(obs), 0);
            end
        end
    end

    initial begin
        int n, g, s;
        clr_L   = 1'b0;
        btn_deb = 1'b1;
        tick(3);
        check("rst_held",  int'(held), 0);
        check("rst_press", int'(press_pulse), 0);
        check("rst_rel",   int'(rel_pulse), 0);
        check("rst_short", int'(short_pulse), 0);
        check("rst_long",  int'(long_pulse), 0);
        check("rst_rpt",   int'(rpt_pulse), 0);
        check("rst_count", int'(press_count), 0);

        clr_L  = 1'b1;
        mon_en = 1'b1;
        tick(50);
        check("idle_count", int'(press_count), 0);

        // Directed: short click, long hold with repeats (release on a repeat
        // hit), release exactly at the long threshold, and one past it.
        do_press(10, 6);
        check("count_after_click", int'(press_count), int'(mcount));
        do_press(40, 6);
        do_press(20, 6);
        do_press(21, 6);

        repeat (30) begin
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, 19);
                1:       n = $urandom_range(20, 21);
                2:       n = $urandom_range(22, 30);
                default: n = $urandom_range(31, 60);
            endcase
            g = $urandom_range(1, 8);
            do_press(n, g);
        end
        tick(8);

        // Reset in LONG_HELD with the button still down: no release, then a
        // fresh press once reset lifts.
        s = cyc + 1;
        btn_deb = 1'b0;
        mcount = mcount + 8'd1;
        push_ev(s + 3, 5'b10000, mcount);
        push_ev(s + 3 + LONG, 5'b00010, mcount);
        set_held(s + 3, s + 3 + LONG);
        tick(LONG + 5);
        clr_L  = 1'b0;
        mcount = 8'd0;
        repeat (3) begin
            tick(1);
            check("midrst_held",  int'(held), 0);
            check("midrst_count", int'(press_count), 0);
            check("midrst_pulses",
                  int'({press_pulse, rel_pulse, short_pulse, long_pulse, rpt_pulse}), 0);
        end
        clr_L = 1'b1;
        do_press(10, 6);
        check("count_after_midrst", int'(press_count), 1);

        repeat (257) do_press(2, 2);
        tick(6);
        check("count_wrap", int'(press_count), int'(mcount));
        check("count_wrap_value", int'(press_count), 2);

        tick(10);
        check("queue_drained", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Consumes the debounced button level from the debouncer and turns it into single-cycle clk_50M event pulses: press, release, short-click, long-press and auto-repeat. It re-synchronizes the debounced level, which is launched from the slow debounce clock, into the clk_50M domain. It then classifies each press by hold duration and keeps a wrapping press count. Its pulses drive the control logic that steps through data words and triggers error injection.

## Interface
- ACTIVE_LOW, 1: polarity of btn_deb. 1 means 0 = pressed, matching the board push-buttons.
- LONG_CNT, 50_000_000: hold length in clk_50M cycles that qualifies as a long press (1 s).
- REPEAT_CNT, 12_500_000: auto-repeat period in cycles once long-held (250 ms).
- CNT_W, 32: hold-counter width. Must satisfy 2^CNT_W > max(LONG_CNT, REPEAT_CNT).
- clk_50M  input  1  50 MHz system clock.
- clr_L  input  1  reset; asynchronous, active-low.
- btn_deb  input  1  debounced button level; asynchronous to clk_50M.
- held  output  1  registered internal "pressed" level after synchronization.
- press_pulse  output  1  one-cycle pulse on press.
- rel_pulse  output  1  one-cycle pulse on every release.
- short_pulse  output  1  one-cycle pulse on release before the long threshold.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_CNT.
- rpt_pulse  output  1  one-cycle pulse every REPEAT_CNT cycles while long-held.
- press_count  output  8  number of presses since reset, modulo 256.

## Operation
- Input path: btn_deb goes through a 2-flop synchronizer (s1, s2).
  - The level is normalized: p = s2 ^ ACTIVE_LOW, so p = 1 means pressed.
  - A third flop, p_q, holds the previous p.
  - Edge detection: rise = p & ~p_q; fall = ~p & p_q.
- Sync flops reset to the released level. If the button is held through reset release, one press_pulse is generated after reset.
- State machine:
  - IDLE: wait for rise, then go to PRESSED.
  - PRESSED: on fall, go to IDLE. When the hold counter reaches LONG_CNT-1, go to LONG_HELD.
  - LONG_HELD: on fall, go to IDLE. Otherwise remain.
- Hold counter:
  - Cleared to 0 on entry to PRESSED and on entry to LONG_HELD.
  - Increments by 1 each cycle in PRESSED and LONG_HELD. Held at 0 in IDLE.
- Pulse generation (all outputs registered, each 1 cycle wide):
  - press_pulse: on IDLE→PRESSED. press_count increments on the same edge; 255 wraps to 0.
  - rel_pulse: on any fall while in PRESSED or LONG_HELD.
  - short_pulse: on fall from PRESSED only.
  - long_pulse: on the PRESSED→LONG_HELD transition, exactly once per press.
  - rpt_pulse: in LONG_HELD, when the counter reaches REPEAT_CNT-1. The counter then wraps to 0 and repeats.
- held follows p registered, i.e. it equals state != IDLE.
- Simultaneous events:
  - Fall in the same cycle the counter hits LONG_CNT-1: release wins. short_pulse and rel_pulse fire; long_pulse does not.
  - Fall in the same cycle as a repeat hit: rel_pulse only, no rpt_pulse.
- Reset (clr_L low, any time):
  - State goes to IDLE; counter, s1, s2 and p_q to released.
  - All pulses, held and press_count go to 0 immediately.
  - No release event is produced for a press interrupted by reset.

## Timing
- Reset values: held = 0, all pulse outputs = 0, press_count = 0.
- press_pulse is high in the 4th clk_50M cycle after the first rising edge that samples btn_deb pressed. Stages: s1, s2, p_q/edge, output register.
- rel_pulse and short_pulse have the same 4-cycle latency from release.
- long_pulse asserts LONG_CNT cycles after press_pulse.
- The first rpt_pulse asserts REPEAT_CNT cycles after long_pulse; later ones are spaced REPEAT_CNT apart.
- At most one of press_pulse, rel_pulse, long_pulse and rpt_pulse is high in any cycle. short_pulse is always coincident with rel_pulse.
- Minimum press length that is detected: 1 sampled cycle of p. btn_deb changes at ≤15 Hz, so no further filtering is applied.

## Test plan
Run with LONG_CNT = 20, REPEAT_CNT = 5, ACTIVE_LOW = 1.
- Reset: clr_L low with btn_deb = 1 → all outputs 0. Release reset, hold btn_deb = 1 for 50 cycles → no pulses, press_count = 0.
- Short click: btn_deb = 0 for 10 cycles → press_pulse at cycle 4, held high, then short_pulse + rel_pulse 4 cycles after release. press_count = 1; long_pulse never asserts.
- Long hold with repeat: btn_deb = 0 for 40 cycles → press_pulse, then long_pulse 20 cycles later. rpt_pulse 5, 10 and 15 cycles after long_pulse; release gives rel_pulse only, no short_pulse.
- Boundary: release timed so fall coincides with counter = 19 → short_pulse + rel_pulse; no long_pulse.
- Wrap: 257 short clicks → press_count = 1.
- Reset mid-hold: clr_L low 3 cycles during LONG_HELD with btn_deb = 0 → outputs cleared, no rel_pulse. After reset, one new press_pulse fires 4 cycles after clr_L rises.
